// File: rtl/micro_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : micro_sequencer_if
//  Description : Bus bundle between the micro-sequencer and its environment:
//                control inputs (start, stall, instruction byte, ALU busy)
//                and sequencer outputs (micro-step code, status, counter).
//  Revision    : 1.0  initial release
// ============================================================================
interface micro_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             stall;
  logic [7:0]       ir;
  logic             alu_busy;
  logic [7:0]       operand;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  // Environment side: drives control inputs, observes the sequencer.
  modport master (
    output start, stall, ir, alu_busy,
    input  operand, halted, illegal, instr_count
  );

  // Sequencer side.
  modport slave (
    input  start, stall, ir, alu_busy,
    output operand, halted, illegal, instr_count
  );
endinterface
`default_nettype wire

// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : micro_sequencer
//  Description : Control-unit state machine producing the 8-bit micro-step
//                code for the control-signal decoder. Runs the three-step
//                fetch, dispatches on the latched instruction byte, walks
//                the instruction's micro-steps and returns to fetch. Counts
//                retired instructions.
//  Revision    : 1.0  initial release
// ============================================================================
module micro_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  micro_sequencer_if.slave   bus
);

  // Micro-step codes. First steps of each instruction are the values the
  // instruction byte may legally carry.
  typedef enum logic [7:0] {
    S_FETCH   = 8'h01,
    S_FETCH_2 = 8'h02,
    S_FETCH_3 = 8'h03,
    S_LODK    = 8'h10,
    S_LODK_2  = 8'h11,
    S_LADD    = 8'h20,
    S_LADD_2  = 8'h21,
    S_LADD_3  = 8'h22,
    S_LADD_4  = 8'h23,
    S_LADD_5  = 8'h24,
    S_LADD_6  = 8'h25,
    S_LADD_7  = 8'h26,
    S_LOAD    = 8'h30,
    S_LOAD_2  = 8'h31,
    S_LOAD_3  = 8'h32,
    S_STAC    = 8'h40,
    S_COPY    = 8'h50,
    S_COPY_2  = 8'h51,
    S_RSET    = 8'h60,
    S_RSET_2  = 8'h61,
    S_JUMP    = 8'h70,
    S_JUMP_2  = 8'h71,
    S_INCR    = 8'h80,
    S_INCR_2  = 8'h81,
    S_DECR    = 8'h90,
    S_DECR_2  = 8'h91,
    S_ADD     = 8'hA0,
    S_SUBT    = 8'hA8,
    S_DIV     = 8'hB0,
    S_DIV_2   = 8'hB1,
    S_MUL     = 8'hC0,
    S_MUL_2   = 8'hC1,
    S_TOGL    = 8'hD0,
    S_NOOP    = 8'hE0,
    S_END     = 8'hFF
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             illegal_pend;
  logic             retire;
  logic             illegal_reg;
  logic [CNT_W-1:0] count;

  // State, illegal flag and retired-instruction counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_END;
      illegal_reg <= 1'b0;
      count       <= '0;
    end else begin
      state       <= next_state;
      illegal_reg <= illegal_pend;
      if (retire) begin
        count <= count + 1'b1;
      end
    end
  end

  // Next micro-step, illegal-dispatch detection and retire strobe.
  always_comb begin
    next_state   = state;
    illegal_pend = 1'b0;
    retire       = 1'b0;
    if (state == S_END) begin
      // Halted: only start leaves, and stall does not block it.
      if (bus.start) begin
        next_state = S_FETCH;
      end
    end else if (!bus.stall) begin
      case (state)
        S_FETCH:   next_state = S_FETCH_2;
        S_FETCH_2: next_state = S_FETCH_3;
        S_FETCH_3: begin
          case (bus.ir)
            S_LODK, S_LADD, S_LOAD, S_STAC, S_COPY, S_RSET, S_JUMP,
            S_INCR, S_DECR, S_ADD, S_SUBT, S_DIV, S_MUL, S_TOGL,
            S_NOOP: begin
              next_state = state_t'(bus.ir);
            end
            S_END: begin
              // Halt instruction retires as it enters END.
              next_state = S_END;
              retire     = 1'b1;
            end
            default: begin
              // Non-first steps and unknown bytes execute as NOOP.
              next_state   = S_NOOP;
              illegal_pend = 1'b1;
            end
          endcase
        end
        S_LODK:    next_state = S_LODK_2;
        S_LADD:    next_state = S_LADD_2;
        S_LADD_2:  next_state = S_LADD_3;
        S_LADD_3:  next_state = S_LADD_4;
        S_LADD_4:  next_state = S_LADD_5;
        S_LADD_5:  next_state = S_LADD_6;
        S_LADD_6:  next_state = S_LADD_7;
        S_LOAD:    next_state = S_LOAD_2;
        S_LOAD_2:  next_state = S_LOAD_3;
        S_COPY:    next_state = S_COPY_2;
        S_RSET:    next_state = S_RSET_2;
        S_JUMP:    next_state = S_JUMP_2;
        S_INCR:    next_state = S_INCR_2;
        S_DECR:    next_state = S_DECR_2;
        S_DIV:     next_state = S_DIV_2;
        S_MUL:     next_state = S_MUL_2;
        S_LODK_2, S_LADD_7, S_LOAD_3, S_STAC, S_COPY_2, S_RSET_2,
        S_JUMP_2, S_INCR_2, S_DECR_2, S_ADD, S_SUBT, S_TOGL,
        S_NOOP: begin
          next_state = S_FETCH;
          retire     = 1'b1;
        end
        S_DIV_2, S_MUL_2: begin
          // Multi-cycle ALU ops wait here until the ALU is free.
          if (!bus.alu_busy) begin
            next_state = S_FETCH;
            retire     = 1'b1;
          end
        end
        default:   next_state = S_END;
      endcase
    end
  end

  assign bus.operand     = state;
  assign bus.halted      = (state == S_END);
  assign bus.illegal     = illegal_reg;
  assign bus.instr_count = count;

endmodule
`default_nettype wire

// File: tb/tb_micro_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_micro_sequencer
//  Description : Directed scoreboard bench. Two sequencers (16-bit and 4-bit
//                counters) share one stimulus stream; the stimulus side queues
//                the expected micro-step, illegal flag and count for each
//                edge, a negedge monitor pops and compares.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_micro_sequencer;

  localparam logic [7:0] C_FETCH   = 8'h01;
  localparam logic [7:0] C_FETCH_2 = 8'h02;
  localparam logic [7:0] C_FETCH_3 = 8'h03;
  localparam logic [7:0] C_LODK    = 8'h10;
  localparam logic [7:0] C_LODK_2  = 8'h11;
  localparam logic [7:0] C_LADD    = 8'h20;
  localparam logic [7:0] C_LADD_2  = 8'h21;
  localparam logic [7:0] C_LADD_3  = 8'h22;
  localparam logic [7:0] C_LADD_4  = 8'h23;
  localparam logic [7:0] C_LADD_5  = 8'h24;
  localparam logic [7:0] C_LADD_6  = 8'h25;
  localparam logic [7:0] C_LADD_7  = 8'h26;
  localparam logic [7:0] C_LOAD    = 8'h30;
  localparam logic [7:0] C_LOAD_2  = 8'h31;
  localparam logic [7:0] C_LOAD_3  = 8'h32;
  localparam logic [7:0] C_STAC    = 8'h40;
  localparam logic [7:0] C_DIV     = 8'hB0;
  localparam logic [7:0] C_DIV_2   = 8'hB1;
  localparam logic [7:0] C_MUL     = 8'hC0;
  localparam logic [7:0] C_MUL_2   = 8'hC1;
  localparam logic [7:0] C_NOOP    = 8'hE0;
  localparam logic [7:0] C_END     = 8'hFF;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stall;
  logic       alu_busy;
  logic [7:0] ir;

  always #5 clk = ~clk;

  micro_sequencer_if #(.CNT_W(16)) bus16 ();
  micro_sequencer_if #(.CNT_W(4))  bus4 ();

  assign bus16.start    = start;
  assign bus16.stall    = stall;
  assign bus16.ir       = ir;
  assign bus16.alu_busy = alu_busy;
  assign bus4.start     = start;
  assign bus4.stall     = stall;
  assign bus4.ir        = ir;
  assign bus4.alu_busy  = alu_busy;

  micro_sequencer #(.CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  micro_sequencer #(.CNT_W(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

  typedef struct {
    int         cyc;
    logic [7:0] op;
    logic       ill;
    int         cnt;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cur_cyc  = 0;
  int   ecnt     = 0;
  int   checks   = 0;
  int   failures = 0;

  // Edge counter used to align queued expectations with DUT outputs.
  always @(posedge clk) cur_cyc <= cur_cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cur_cyc, act, req);
    end
  endtask

  // Monitor: compare every queued expectation that has come due.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cur_cyc) begin
      mon_e = q.pop_front();
      chk("operand",     int'(bus16.operand),     int'(mon_e.op));
      chk("halted",      int'(bus16.halted),      int'(mon_e.op == C_END));
      chk("illegal",     int'(bus16.illegal),     int'(mon_e.ill));
      chk("instr_count", int'(bus16.instr_count), mon_e.cnt & 16'hFFFF);
      chk("count4",      int'(bus4.instr_count),  mon_e.cnt & 4'hF);
      chk("operand4",    int'(bus4.operand),      int'(mon_e.op));
    end
  end

  // One clock: apply inputs, queue expected state after the coming edge.
  task automatic cyc(input logic r, input logic s, input logic sl,
                     input logic [7:0] i, input logic b,
                     input logic [7:0] eop, input logic eill);
    exp_t e;
    rst = r; start = s; stall = sl; ir = i; alu_busy = b;
    if (r) ecnt = 0;
    e.cyc = cur_cyc + 1;
    e.op  = eop;
    e.ill = eill;
    e.cnt = ecnt;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [7:0] i, input logic [7:0] eop);
    cyc(1'b0, 1'b0, 1'b0, i, 1'b0, eop, 1'b0);
  endtask

  // Edge leaving a last step: back to FETCH, one more instruction retired.
  task automatic retire_go();
    ecnt++;
    go(8'h00, C_FETCH);
  endtask

  // From FETCH: FETCH_2, FETCH_3, then dispatch ir.
  task automatic fetch_dispatch(input logic [7:0] i, input logic [7:0] eop);
    go(8'h00, C_FETCH_2);
    go(8'h00, C_FETCH_3);
    go(i, eop);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; ir = 8'h00; alu_busy = 1'b0;

    // Reset, then start.
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, C_END, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, C_END, 1'b0);
    go(8'h00, C_END);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, C_FETCH, 1'b0);

    // LADD: seven steps, retires leaving LADD_7.
    fetch_dispatch(C_LADD, C_LADD);
    go(8'h00, C_LADD_2);
    go(8'h00, C_LADD_3);
    go(8'h00, C_LADD_4);
    go(8'h00, C_LADD_5);
    go(8'h00, C_LADD_6);
    go(8'h00, C_LADD_7);
    retire_go();

    // DIV: busy ignored in DIV, DIV_2 held 5 extra cycles.
    fetch_dispatch(C_DIV, C_DIV);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, C_DIV_2, 1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, C_DIV_2, 1'b0);
    retire_go();

    // MUL with ALU free: MUL_2 for one cycle.
    fetch_dispatch(C_MUL, C_MUL);
    go(8'h00, C_MUL_2);
    retire_go();

    // Illegal (non-first step) dispatch.
    go(8'h00, C_FETCH_2);
    go(8'h00, C_FETCH_3);
    cyc(1'b0, 1'b0, 1'b0, C_LADD_3, 1'b0, C_NOOP, 1'b1);
    retire_go();

    // LOAD with a 3-cycle stall in LOAD_2.
    fetch_dispatch(C_LOAD, C_LOAD);
    go(8'h00, C_LOAD_2);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, C_LOAD_2, 1'b0);
    go(8'h00, C_LOAD_3);
    retire_go();

    // Start ignored in FETCH; END dispatch halts and retires.
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, C_FETCH_2, 1'b0);
    go(8'h00, C_FETCH_3);
    ecnt++;
    go(C_END, C_END);
    go(C_LADD, C_END);
    // Stall does not block leaving END.
    cyc(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, C_FETCH, 1'b0);

    // Reset in the middle of LADD.
    fetch_dispatch(C_LADD, C_LADD);
    go(8'h00, C_LADD_2);
    go(8'h00, C_LADD_3);
    go(8'h00, C_LADD_4);
    cyc(1'b1, 1'b0, 1'b1, 8'h00, 1'b1, C_END, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, C_FETCH, 1'b0);

    // 16 NOOP instructions: 4-bit counter wraps to 0.
    for (int k = 0; k < 16; k++) begin
      fetch_dispatch(C_NOOP, C_NOOP);
      retire_go();
    end

    // LODK and STAC.
    fetch_dispatch(C_LODK, C_LODK);
    go(8'h00, C_LODK_2);
    retire_go();
    fetch_dispatch(C_STAC, C_STAC);
    retire_go();

    @(posedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Control-unit state machine that generates the 8-bit micro-step code (`operand`) consumed by the control-signal decoder.
- Walks FETCH, FETCH_2 and FETCH_3, dispatches on the instruction byte latched in IR, then steps through that instruction's micro-steps and returns to FETCH.
- Sits between the instruction register / ALU status and the decoder. All state codes are the `opcode_define.v` macros.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; leaves the halted (`END`) state.
- stall  in  1  memory wait; holds the current micro-step while high.
- ir  in  8  instruction byte; sampled only while operand==`FETCH_3`.
- alu_busy  in  1  multi-cycle ALU busy; holds `DIV_2`/`MUL_2` while high.
- operand  out  8  current micro-step code, registered; drives the decoder.
- halted  out  1  high while operand==`END`.
- illegal  out  1  one-cycle pulse when the dispatched ir is not a legal first step.
- instr_count  out  CNT_W  number of instructions retired since reset.

Behaviour:
- Reset, synchronous on rst=1 at the clk edge:
  - operand=`END`, halted=1, illegal=0, instr_count=0.
  - rst overrides every other input, including in mid-instruction or mid-stall.
- operand is a register; any next-state decision appears on operand one cycle after the deciding edge. halted is combinational from operand.
- Hold priority, highest first: rst, then stall, then alu_busy (only in `DIV_2`/`MUL_2`), then normal transition.
  - stall=1 in any state other than `END`: operand holds, no counter update, no illegal pulse.
- `END`: holds until start=1, then goes to `FETCH`. start in any other state is ignored. stall does not block leaving `END`.
- Fetch chain: `FETCH` -> `FETCH_2` -> `FETCH_3` -> dispatch.
- Dispatch from `FETCH_3`: next state = ir when ir is one of:
  - `LODK`, `LADD`, `LOAD`, `STAC`, `COPY`, `RSET`, `JUMP`, `INCR`, `DECR`, `ADD`, `SUBT`, `DIV`, `MUL`, `togL`, `NOOP`, `END`.
  - Any other value, including a non-first step such as `LADD_3`: next = `NOOP` and illegal=1 for exactly the cycle after dispatch.
- Instruction chains (last step -> `FETCH`):
  - `LODK` -> `LODK_2`
  - `LADD` -> `LADD_2` -> `LADD_3` -> `LADD_4` -> `LADD_5` -> `LADD_6` -> `LADD_7`
  - `LOAD` -> `LOAD_2` -> `LOAD_3`
  - `COPY` -> `COPY_2`; `RSET` -> `RSET_2`; `JUMP` -> `JUMP_2`; `INCR` -> `INCR_2`; `DECR` -> `DECR_2`
  - `DIV` -> `DIV_2`; `MUL` -> `MUL_2`
  - `STAC`, `ADD`, `SUBT`, `togL`, `NOOP`: single step.
- `DIV_2`/`MUL_2` exit to `FETCH` on the first cycle with alu_busy=0. alu_busy is ignored in every other state.
- Dispatch of `END` halts. The halt counts as a retired instruction.
- instr_count:
  - Increments by 1 on the edge that leaves the last step of an instruction (including `NOOP` substituted for an illegal ir), and on the edge that enters `END` from `FETCH_3`.
  - Wraps from all-ones to 0; no saturation.
- Any operand value not listed above (unreachable except by fault) -> next = `END`, no count.

Test Plan:
- rst=1 for 2 cycles, then start pulse -> operand=`END` and halted=1 during reset; operand=`FETCH` one cycle after start; `FETCH_2`, `FETCH_3` follow.
- ir=`LADD` at `FETCH_3` -> operand steps `LADD` ... `LADD_7` over 7 consecutive cycles, then `FETCH`; instr_count 0->1 on the edge leaving `LADD_7`.
- ir=`DIV`, alu_busy=1 for 5 cycles after entering `DIV_2` -> operand stays `DIV_2` 6 cycles total, then `FETCH`; repeat with `MUL` and alu_busy=0 -> `MUL_2` lasts 1 cycle.
- ir=`LADD_3` (illegal) at `FETCH_3` -> operand=`NOOP`, illegal=1 for 1 cycle, next `FETCH`, instr_count+1.
- stall=1 for 3 cycles while operand=`LOAD_2` -> operand frozen 3 extra cycles, instr_count unchanged; then `LOAD_3` -> `FETCH`.
- ir=`END` at `FETCH_3` -> operand=`END`, halted=1, instr_count+1; start ignored while operand=`FETCH`; rst asserted mid-`LADD_4` -> operand=`END`, instr_count=0 next cycle. Separately, with CNT_W=4, retire 16 `NOOP` instructions -> instr_count wraps to 0.
